min_pipe_stage: RTL
===================

# min_pipe_stage

Elastic, parametrised pipeline register between minimum-search stages (e.g. MIN2 to MIN3). It carries a boss-trigger flag and NUM_MIN (index, value) candidate pairs, with a valid/ready handshake. A two-entry skid buffer gives full throughput with a registered `in_ready`. It adds synchronous flush and a saturating downstream-stall counter for performance debug.

## Interface
- `IDX_W`, 16, width of one candidate index
- `VAL_W`, 14, width of one candidate value
- `NUM_MIN`, 2, number of candidate pairs per beat (1..8)
- `STALL_W`, 16, width of stall counter

- `clk`  in  1  clock; all state changes on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `flush`  in  1  synchronous drop of all held beats
- `in_valid`  in  1  upstream beat present
- `in_ready`  out  1  stage can accept; registered
- `in_trigger`  in  1  boss-trigger flag of beat
- `in_index`  in  NUM_MIN*IDX_W  packed indices, pair 0 in LSBs
- `in_value`  in  NUM_MIN*VAL_W  packed values, pair 0 in LSBs
- `out_valid`  out  1  beat presented downstream; registered
- `out_ready`  in  1  downstream accepts
- `out_trigger`  out  1  trigger of presented beat
- `out_index`  out  NUM_MIN*IDX_W  indices of presented beat
- `out_value`  out  NUM_MIN*VAL_W  values of presented beat
- `stall_count`  out  STALL_W  cycles with out_valid=1, out_ready=0

## Operation
- Storage: main register (drives outputs) plus skid register; each holds trigger, index, value and a valid bit.
- Transfers: input accepted when `in_valid && in_ready`. Output consumed when `out_valid && out_ready`.
- States:
  - EMPTY: main and skid empty.
  - ONE: main full.
  - TWO: main and skid full.
- EMPTY transitions:
  - Accept: data loads into main, go to ONE.
- ONE transitions:
  - Accept and consume: main reloads from input, stay in ONE.
  - Consume only: go to EMPTY.
  - Accept only: data loads into skid, go to TWO.
- TWO transitions:
  - Consume: skid moves to main, go to ONE.
  - Accept is impossible in TWO (`in_ready`=0).
- `in_ready` = 1 in EMPTY/ONE, 0 in TWO; derived from registered state only, with no combinational path from `out_ready`.
- Beats leave in acceptance order. Payload is passed bit-exact; the stage does no arithmetic on index/value.
- `flush`:
  - Next state is EMPTY; both valid bits clear.
  - A beat offered in the flush cycle is dropped, even if `in_ready`=1.
  - A consume in the flush cycle still counts as a completed transfer downstream.
  - Flush has priority over every other event.
- `stall_count`:
  - Increments each cycle with `out_valid && !out_ready`.
  - Saturates at all-ones and does not wrap.
  - Cleared only by `rst`; `flush` does not clear it.
- Reset (asynchronous, immediate):
  - State EMPTY.
  - `out_valid`=0, `in_ready`=1.
  - `out_trigger`, `out_index`, `out_value` and skid contents = 0.
  - `stall_count`=0.
- Payload registers change only when loaded; with `out_valid`=0 the outputs hold their last value (0 after reset).

## Timing
- Latency: a beat accepted at edge N appears with `out_valid`=1 after edge N (visible cycle N+1).
- Throughput: 1 beat/cycle while `out_ready`=1 continuously.
- Backpressure: `out_ready` low for one cycle with a beat arriving fills skid. `in_ready` drops after that edge and returns high one cycle after the next consume.
- Output stability: while `out_valid && !out_ready`, all `out_*` hold constant.
- Simultaneous accept+consume in ONE: no bubble, no skid use.
- Reset asserted mid-transfer: in-flight beats lost; first post-reset accept is a normal EMPTY load.

## Test plan
- Reset then stream: `rst` pulse, then 8 beats back-to-back with index 0..7, values 0x100+i, `out_ready`=1. Required: outputs appear one cycle after each accept, in order; `in_ready` stays 1; `stall_count`=0.
- Backpressure skid:
  - Stimulus: beats A (trigger=1), B, C offered continuously; `out_ready`=0 for 3 cycles, then 1.
  - Required: A held stable on outputs and B held in skid; `in_ready`=0 while both held; C accepted only after A consumed; order A,B,C; `stall_count`=3.
- Flush: state TWO, `flush`=1 with `in_valid`=1 beat D. Required: next cycle `out_valid`=0, `in_ready`=1; D never emitted; `stall_count` unchanged.
- Saturation: STALL_W=4, `out_valid` held with `out_ready`=0 for 20 cycles. Required: `stall_count` reaches 15 and stays.
- Async reset mid-stream: assert `rst` between edges while in TWO. Required: `out_valid`=0, `in_ready`=1, `out_index`=0 immediately, without waiting for a clock edge.
- Parameter sweep: NUM_MIN=1, 2, 4 with IDX_W=8, VAL_W=10. Required: random beats with random `out_ready` come out bit-exact and in order, checked against a reference queue model.

Source files
------------

// File: rtl/min_pipe_stage.sv
// Elastic pipeline register between minimum-search stages: main + skid buffer,
// registered handshake, synchronous flush and a saturating downstream-stall counter.
module min_pipe_stage #(
    parameter int unsigned IDX_W   = 16,
    parameter int unsigned VAL_W   = 14,
    parameter int unsigned NUM_MIN = 2,
    parameter int unsigned STALL_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_trigger,
    input  logic [NUM_MIN*IDX_W-1:0]   in_index,
    input  logic [NUM_MIN*VAL_W-1:0]   in_value,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_trigger,
    output logic [NUM_MIN*IDX_W-1:0]   out_index,
    output logic [NUM_MIN*VAL_W-1:0]   out_value,
    output logic [STALL_W-1:0]         stall_count
);

    localparam int unsigned IW = NUM_MIN * IDX_W;
    localparam int unsigned VW = NUM_MIN * VAL_W;
    localparam logic [STALL_W-1:0] STALL_MAX = '1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e               state_q;
    logic                 in_ready_q;
    logic                 main_valid_q;
    logic                 main_trig_q;
    logic [IW-1:0]        main_idx_q;
    logic [VW-1:0]        main_val_q;
    logic                 skid_valid_q;
    logic                 skid_trig_q;
    logic [IW-1:0]        skid_idx_q;
    logic [VW-1:0]        skid_val_q;
    logic [STALL_W-1:0]   stall_q;

    logic accept;
    logic consume;

    assign accept  = in_valid && in_ready_q;
    assign consume = main_valid_q && out_ready;

    // Handshake FSM; in_ready is a pure function of the registered state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= EMPTY;
            in_ready_q   <= 1'b1;
            main_valid_q <= 1'b0;
            main_trig_q  <= 1'b0;
            main_idx_q   <= '0;
            main_val_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_trig_q  <= 1'b0;
            skid_idx_q   <= '0;
            skid_val_q   <= '0;
            stall_q      <= '0;
        end else begin
            if (main_valid_q && !out_ready && (stall_q != STALL_MAX)) begin
                stall_q <= stall_q + STALL_W'(1);
            end

            if (flush) begin
                state_q      <= EMPTY;
                in_ready_q   <= 1'b1;
                main_valid_q <= 1'b0;
                skid_valid_q <= 1'b0;
            end else begin
                case (state_q)
                    EMPTY: begin
                        if (accept) begin
                            main_trig_q  <= in_trigger;
                            main_idx_q   <= in_index;
                            main_val_q   <= in_value;
                            main_valid_q <= 1'b1;
                            state_q      <= ONE;
                        end
                    end
                    ONE: begin
                        if (accept && consume) begin
                            main_trig_q <= in_trigger;
                            main_idx_q  <= in_index;
                            main_val_q  <= in_value;
                        end else if (consume) begin
                            main_valid_q <= 1'b0;
                            state_q      <= EMPTY;
                        end else if (accept) begin
                            skid_trig_q  <= in_trigger;
                            skid_idx_q   <= in_index;
                            skid_val_q   <= in_value;
                            skid_valid_q <= 1'b1;
                            in_ready_q   <= 1'b0;
                            state_q      <= TWO;
                        end
                    end
                    TWO: begin
                        if (consume) begin
                            main_trig_q  <= skid_trig_q;
                            main_idx_q   <= skid_idx_q;
                            main_val_q   <= skid_val_q;
                            skid_valid_q <= 1'b0;
                            in_ready_q   <= 1'b1;
                            state_q      <= ONE;
                        end
                    end
                    default: begin
                        state_q      <= EMPTY;
                        in_ready_q   <= 1'b1;
                        main_valid_q <= 1'b0;
                        skid_valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = main_valid_q;
    assign out_trigger = main_trig_q;
    assign out_index   = main_idx_q;
    assign out_value   = main_val_q;
    assign stall_count = stall_q;

endmodule
